// File: rtl/bitstream_pkg.sv
// Shared types and constants for the stochastic bitstream encoder.
package bitstream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, TAIL, GAP} gen_state_t;

  localparam int unsigned MODE_BITREV   = 0;
  localparam int unsigned MODE_DEBRUIJN = 1;

  // Maximal-length Fibonacci tap masks; bit t-1 set for tap t.
  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    case (width)
      4:       lfsr_taps = 16'h000C;
      5:       lfsr_taps = 16'h0014;
      6:       lfsr_taps = 16'h0030;
      7:       lfsr_taps = 16'h0060;
      8:       lfsr_taps = 16'h00B8;
      9:       lfsr_taps = 16'h0110;
      10:      lfsr_taps = 16'h0240;
      11:      lfsr_taps = 16'h0500;
      12:      lfsr_taps = 16'h0829;
      13:      lfsr_taps = 16'h100D;
      14:      lfsr_taps = 16'h2015;
      15:      lfsr_taps = 16'h6000;
      16:      lfsr_taps = 16'hD008;
      default: lfsr_taps = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/bitstream_sequence.sv
// Comparison sequence source: bit-reversed counter or de Bruijn LFSR, both
// visiting every WIDTH-bit value exactly once per 2**WIDTH steps.
module bitstream_sequence
  import bitstream_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      MODE  = 0,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             advance,
  output logic [WIDTH-1:0] seq
);

  if (MODE == MODE_DEBRUIJN) begin : g_debruijn
    localparam logic [15:0]      TAP_ALL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS    = TAP_ALL[WIDTH-1:0];

    logic [WIDTH-1:0] lfsr;
    logic             fb;

    // NOR of the low bits splices the all-zero state in after 100..0.
    always_comb fb = (^(lfsr & TAPS)) ^ (lfsr[WIDTH-2:0] == '0);

    always_ff @(posedge clk or posedge rst) begin
      if (rst)          lfsr <= SEED;
      else if (init)    lfsr <= SEED;
      else if (advance) lfsr <= {lfsr[WIDTH-2:0], fb};
    end

    always_comb seq = lfsr;
  end else begin : g_bitrev
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)          cnt <= '0;
      else if (init)    cnt <= '0;
      else if (advance) cnt <= cnt + WIDTH'(1);
    end

    always_comb begin
      seq = '0;
      for (int unsigned i = 0; i < WIDTH; i++) seq[i] = cnt[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/bitstream_generator.sv
// Encodes a binary magnitude as a unipolar stochastic bitstream over a
// 2**WIDTH-cycle window, framed by capture and followed by a done pulse.
module bitstream_generator
  import bitstream_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      MODE  = 0,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WIDTH:0] value,
  input  logic           start,
  output logic           busy,
  output logic           capture,
  output logic           x,
  output logic           done
);

  localparam logic [WIDTH:0] L = {1'b1, {WIDTH{1'b0}}};

  gen_state_t       state, state_nxt;
  logic [WIDTH-1:0] k;
  logic [WIDTH:0]   value_q;
  logic [WIDTH-1:0] seq;
  logic             init;

  bitstream_sequence #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .SEED  (SEED)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .init    (init),
    .advance (state == RUN),
    .seq     (seq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    init      = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        init      = 1'b1;
      end
      RUN:     if (k == '1) state_nxt = TAIL;
      TAIL:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture = (state == RUN);
    busy    = (state != IDLE);
    done    = (state == GAP);
  end

  // x lags capture by one cycle, so TAIL shows the final stream bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= '0;
      value_q <= '0;
      x       <= 1'b0;
    end else begin
      x <= (state == RUN) && ({1'b0, seq} < value_q);
      if (init) begin
        k       <= '0;
        value_q <= (value > L) ? L : value;
      end else if (state == RUN) begin
        k <= k + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_bitstream_generator.sv
// Scoreboard bench: two WIDTH=4 instances (bit-reverse and de Bruijn) share stimulus.
module tb_bitstream_generator;

  localparam int unsigned W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [W:0] value = '0;
  logic [1:0] busy, cap, x, done;

  bitstream_generator #(.WIDTH(W), .MODE(0), .SEED(4'd1)) dut0 (
    .clk(clk), .rst(rst), .value(value), .start(start),
    .busy(busy[0]), .capture(cap[0]), .x(x[0]), .done(done[0]));

  bitstream_generator #(.WIDTH(W), .MODE(1), .SEED(4'd9)) dut1 (
    .clk(clk), .rst(rst), .value(value), .start(start),
    .busy(busy[1]), .capture(cap[1]), .x(x[1]), .done(done[1]));

  always #5 clk = ~clk;

  typedef struct {
    int          ones;
    int          start_cyc;
    logic [15:0] pat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-reversed-counter stream: bit k is 1 when reverse(k) < v.
  function automatic logic [15:0] mode0_pattern(input int v);
    logic [15:0] p;
    logic [3:0]  kk, r;
    for (int k = 0; k < 16; k++) begin
      kk   = 4'(k);
      r    = {kk[0], kk[1], kk[2], kk[3]};
      p[k] = (int'(r) < v);
    end
    return p;
  endfunction

  task automatic expect_window(input int v, input int sc);
    exp_t e;
    e.ones      = (v > 16) ? 16 : v;
    e.start_cyc = sc;
    e.pat       = mode0_pattern(e.ones);
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic pulse_start(input int v);
    @(posedge clk); #1;
    value = 5'(v);
    start = 1'b1;
    expect_window(v, cyc + 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (22) @(posedge clk);
    #1;
    chk({name, " pending windows mode0"}, q0.size(), 0);
    chk({name, " pending windows mode1"}, q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  // Monitor: accumulate each window and score it when done appears.
  int          ones [2];
  int          nx [2];
  int          cap_len [2];
  int          cap_start [2];
  logic [15:0] xbits [2];
  logic [1:0]  prev_cap;

  always @(negedge clk) begin
    exp_t e;
    logic have;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        ones[d] = 0; nx[d] = 0; cap_len[d] = 0; cap_start[d] = 0;
        xbits[d] = '0; prev_cap[d] = 1'b0;
      end else begin
        if (!prev_cap[d]) chk($sformatf("x idle low dut%0d", d), int'(x[d]), 0);
        else begin
          if (nx[d] < 16) xbits[d][nx[d]] = x[d];
          ones[d] += int'(x[d]);
          nx[d]++;
        end
        if (cap[d] && !prev_cap[d]) begin
          cap_start[d] = cyc;
          cap_len[d]   = 0;
        end
        if (cap[d]) cap_len[d]++;
        chk($sformatf("busy dut%0d", d), int'(busy[d]),
            int'(cap[d] | prev_cap[d] | done[d]));
        if (done[d]) begin
          have = 1'b0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          if (!have) chk($sformatf("unexpected done dut%0d", d), 1, 0);
          else begin
            chk($sformatf("ones count dut%0d", d), ones[d], e.ones);
            chk($sformatf("capture length dut%0d", d), cap_len[d], 16);
            chk($sformatf("x bit count dut%0d", d), nx[d], 16);
            chk($sformatf("capture start dut%0d", d), cap_start[d], e.start_cyc);
            chk($sformatf("done cycle dut%0d", d), cyc, e.start_cyc + 17);
            if (d == 0) chk("x pattern dut0", int'(xbits[0]), int'(e.pat));
          end
          ones[d] = 0;
          nx[d]   = 0;
        end
        prev_cap[d] = cap[d];
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset busy dut%0d", d), int'(busy[d]), 0);
      chk($sformatf("reset capture dut%0d", d), int'(cap[d]), 0);
      chk($sformatf("reset x dut%0d", d), int'(x[d]), 0);
      chk($sformatf("reset done dut%0d", d), int'(done[d]), 0);
    end
    @(posedge clk); #2;
    rst = 1'b0;

    // Half-scale: alternating 1,0,... in mode 0
    pulse_start(8);
    chk("mode0 half-scale pattern", int'(mode0_pattern(8)), 16'h5555);
    drain("t1");

    for (int v = 0; v <= 16; v++) begin
      pulse_start(v);
      drain("t2");
    end

    // Out-of-range clamp, then value change mid-window
    pulse_start(31);
    repeat (4) @(posedge clk);
    #1 value = 5'd3;
    drain("t3");

    // start held: windows 19 cycles apart
    @(posedge clk); #1;
    value = 5'd5;
    start = 1'b1;
    n = cyc;
    expect_window(5, n + 1);
    expect_window(5, n + 20);
    expect_window(5, n + 39);
    repeat (57) @(posedge clk);
    #1 start = 1'b0;
    drain("t4");

    // start during RUN is ignored
    pulse_start(6);
    repeat (3) @(posedge clk);
    #1;
    value = 5'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain("t5");

    // Asynchronous reset mid-RUN aborts without done
    pulse_start(16);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort capture dut%0d", d), int'(cap[d]), 0);
      chk($sformatf("abort x dut%0d", d), int'(x[d]), 0);
      chk($sformatf("abort busy dut%0d", d), int'(busy[d]), 0);
      chk($sformatf("abort done dut%0d", d), int'(done[d]), 0);
    end
    q0.delete();
    q1.delete();
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    pulse_start(11);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitstream_generator.md
Name: bitstream_generator

Overview:
- Converts a binary magnitude into a unipolar stochastic bitstream over a fixed window of 2**WIDTH cycles.
- Produces a `capture` framing strobe alongside the stream, so the stream can drive the network's bitstream accumulators directly.
- Used as the stimulus/encode end of the bitstream datapath. The ones-count over a window is exact: min(value, 2**WIDTH).

Parameters:
- WIDTH, 8, sequence/comparator width; window length L = 2**WIDTH (localparam, not overridable).
- MODE, 0, sequence source: 0 = bit-reversed counter, 1 = de Bruijn LFSR (full period 2**WIDTH, includes zero).
- SEED, 1, de Bruijn LFSR initial state (any value legal); ignored when MODE=0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- value  input  WIDTH+1  magnitude to encode; sampled only on accepted start.
- start  input  1  request a window; accepted only in IDLE.
- busy  output  1  high in RUN, TAIL and GAP.
- capture  output  1  window frame; high for exactly L cycles.
- x  output  1  bitstream; bit k appears one cycle after the k-th capture-high cycle.
- done  output  1  one-cycle pulse after each window completes.

Behaviour:
- Reset: clk and rst only; rst asynchronously forces state IDLE, sequence source to its initial state, and x/capture/busy/done/counter to 0. Reset mid-window aborts the window; no done pulse is produced.
- States (enum, 2 bits):
  - IDLE -> RUN on start. This latches value_q = min(value, L) and reinitialises the sequence source (counter k=0; LFSR=SEED).
  - RUN: capture=1; k increments 0..L-1. The sequence advances each cycle. RUN -> TAIL when k==L-1.
  - TAIL: capture=0; x shows the last stream bit. TAIL -> GAP unconditionally.
  - GAP: capture=0, x=0, done=1. GAP -> IDLE unconditionally.
- x register: x <= (seq < value_q) on every edge while in RUN; x <= 0 on every other edge. Comparator is WIDTH+1 bits, seq zero-extended, so value_q=L gives all ones and value_q=0 gives all zeros.
- Timing: start sampled at edge e0 gives:
  - capture high in cycles 1..L;
  - x valid in cycles 2..L+1;
  - done in cycle L+2;
  - busy in cycles 1..L+2.
  - Earliest next start is sampled in cycle L+3, so capture is low for at least 3 cycles between windows.
- Ones-count: each mode visits every value 0..L-1 exactly once per window, so the count of x=1 in a window equals value_q exactly.
- MODE=0: seq = bit-reverse of k.
- MODE=1: Fibonacci maximal-length LFSR with de Bruijn zero insertion (feedback XOR-ed with NOR of the low WIDTH-1 bits); period L.
- start while busy: ignored, with no queueing. start held high continuously gives back-to-back windows separated by exactly 3 capture-low cycles.
- value changes during a window have no effect.

Decomposition:
- Shared package bitstream_pkg holds:
  - gen_state_t {IDLE, RUN, TAIL, GAP};
  - MODE_BITREV=0 and MODE_DEBRUIJN=1 constants;
  - LFSR tap table indexed by WIDTH (4..16).
- Sub-module bitstream_sequence(clk, rst, init, advance, seq[WIDTH]) holds the MODE-selected counter/LFSR.
- Top-level bitstream_generator holds the FSM, window counter, value latch, comparator and x register.

Test Plan:
1. WIDTH=4, MODE=0, value=8, start pulse at cycle 0 -> capture high cycles 1..16; x over cycles 2..17 = 1,0,1,0,... (8 ones); done only in cycle 18.
2. WIDTH=4, both MODEs, value swept 0..16 -> ones-count per window equals value exactly; value=0 gives no ones, value=16 gives 16 ones.
3. WIDTH=4, value=31 (out of range) -> clamped: 16 ones; value changed to 3 mid-window -> count still 16.
4. start held high for 60 cycles, value=5 -> windows start at cycles 1, 20, 39; capture low exactly 3 cycles between windows; each window has 5 ones.
5. start pulsed again at cycle 5 during RUN -> ignored; exactly one done pulse (cycle 18).
6. rst asserted asynchronously at cycle 9 mid-RUN -> capture, x, busy and done go to 0 immediately, with no done. A new start after rst falls gives a fully correct window.
